pgm_wr: RTL and testbench
=========================

// Module: pgm_wr
// PURPOSE
//  Write-side front end of the packet generator (PGM). Forwards data packets and their PHV to pgm_rd with one register stage.
//  Decodes DMA config packets that write generator program memory (pgm_ram), and passes every config packet down the config chain.
//  Absorbs in-band trigger packets and turns them into start/finish/bypass control for pgm_rd.
// PARAMETERS
//  MODULE_ID  8'd70  Destination module ID this block answers to in config packets ([111:104])
//  RAM_AW     7      Program RAM address width
// PORTS
//  clk                   in   1     system clock
//  rst_n                 in   1     asynchronous active-low reset
//  in_wr_phv             in   1024  PHV from upstream
//  in_wr_phv_wr          in   1     PHV write strobe
//  out_wr_phv_alf        out  1     PHV almost-full to upstream
//  in_wr_data            in   134   packet beat; [133:132] 01=head 11=body 10=tail
//  in_wr_data_wr         in   1     packet beat write strobe
//  in_wr_valid_wr        in   1     packet-valid write strobe
//  in_wr_valid           in   1     packet valid/keep flag
//  out_wr_alf            out  1     data almost-full to upstream
//  out_wr_phv            out  1024  PHV to pgm_rd
//  out_wr_phv_wr         out  1     PHV write strobe to pgm_rd
//  in_wr_phv_alf         in   1     PHV almost-full from pgm_rd
//  out_wr_data           out  134   packet beat to pgm_rd
//  out_wr_data_wr        out  1     beat strobe to pgm_rd
//  out_wr_valid          out  1     packet valid to pgm_rd
//  out_wr_valid_wr       out  1     valid strobe to pgm_rd
//  in_wr_alf             in   1     data almost-full from pgm_rd
//  wr2ram_wr_en          out  1     program RAM write enable
//  wr2ram_wdata          out  144   program RAM write data
//  wr2ram_addr           out  7     program RAM address
//  pgm_bypass_flag       out  1     1 = generator idle, pgm_rd passes traffic through
//  pgm_sent_start_flag   out  1     1-cycle pulse: generation start
//  pgm_sent_finish_flag  out  1     1-cycle pulse: trigger packet complete
//  cin_wr_data           in   134   config beat from DMA
//  cin_wr_data_wr        in   1     config beat strobe
//  cout_wr_ready         out  1     ready to DMA
//  cout_wr_data          out  134   config beat to next module
//  cout_wr_data_wr       out  1     config beat strobe to next module
//  cin_wr_ready          in   1     ready from next module
// BEHAVIOUR
//  - Reset: all outputs 0, except pgm_bypass_flag = 1; state machine returns to IDLE.
//  - Backpressure is combinational: out_wr_alf = in_wr_alf, out_wr_phv_alf = in_wr_phv_alf, cout_wr_ready = cin_wr_ready.
//  - Data FSM:
//    - IDLE: on a head beat (data_wr & [133:132]=01):
//      - [111:109]==3'b111 -> TRIG, beat absorbed, start pulse, bypass <= 0.
//      - otherwise -> FWD, beat forwarded.
//    - FWD: forward each beat; tail (10) -> IDLE.
//    - TRIG: absorb beats; on tail, finish pulse, bypass <= 1, -> IDLE.
//    - Head+tail in the same beat is not supported.
//  - Forwarding: data, data_wr, valid, valid_wr, phv and phv_wr are each registered, so outputs follow inputs by exactly 1 cycle.
//  - PHV passes 1-cycle registered regardless of FSM state, except a trigger packet's PHV is dropped.
//  - Config path: every beat is forwarded to cout_wr_data/_wr with 1-cycle latency.
//  - Config RAM write:
//    - Decode on a head beat when [127]=1 (write), [126:124]=001, [111:104]=MODULE_ID and [95:80]=16'h0001.
//    - Next cycle: wr2ram_wr_en = 1, wr2ram_addr = [70:64], wr2ram_wdata = {80'b0, [63:0]}.
//    - Tail beats and non-matching packets cause no RAM write.
//  - Data and config paths are independent; simultaneous activity on both is legal.
// TESTING
//  - 4-beat packet: head [111:109]=000, then 11, 11, 10 -> same 4 beats on out_wr_data 1 cycle later; flags stay bypass=1, start=0.
//  - Trigger packet: head [111:109]=111 -> start pulse at cycle+1, bypass=0; no out_wr_data_wr; tail -> finish pulse, bypass=1.
//  - Config head to ID 70, addr 32'h00010001, data 64'hffffffff_00000000 -> wr_en=1, addr=1, wdata={80'b0, 64'hffffffff00000000}; beat appears on cout.
//  - Config with dst ID 71 or tail beat -> no wr_en; beat still forwarded on cout after 1 cycle.
//  - Backpressure and reset: in_wr_alf=1 -> out_wr_alf=1 same cycle; rst_n low mid-trigger -> bypass=1, outputs 0.

Source files
------------

// File: rtl/pgm_wr.sv
// Write-side front end of the packet generator: registers data/PHV towards pgm_rd,
// absorbs trigger packets into start/finish/bypass control, and decodes program-RAM writes.
module pgm_wr #(
  parameter logic [7:0]  MODULE_ID = 8'd70,
  parameter int unsigned RAM_AW    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1023:0]     in_wr_phv,
  input  logic              in_wr_phv_wr,
  output logic              out_wr_phv_alf,
  input  logic [133:0]      in_wr_data,
  input  logic              in_wr_data_wr,
  input  logic              in_wr_valid_wr,
  input  logic              in_wr_valid,
  output logic              out_wr_alf,
  output logic [1023:0]     out_wr_phv,
  output logic              out_wr_phv_wr,
  input  logic              in_wr_phv_alf,
  output logic [133:0]      out_wr_data,
  output logic              out_wr_data_wr,
  output logic              out_wr_valid,
  output logic              out_wr_valid_wr,
  input  logic              in_wr_alf,
  output logic              wr2ram_wr_en,
  output logic [143:0]      wr2ram_wdata,
  output logic [RAM_AW-1:0] wr2ram_addr,
  output logic              pgm_bypass_flag,
  output logic              pgm_sent_start_flag,
  output logic              pgm_sent_finish_flag,
  input  logic [133:0]      cin_wr_data,
  input  logic              cin_wr_data_wr,
  output logic              cout_wr_ready,
  output logic [133:0]      cout_wr_data,
  output logic              cout_wr_data_wr,
  input  logic              cin_wr_ready
);

  typedef enum logic [1:0] {StIdle, StFwd, StTrig} state_e;

  state_e state_q, state_d;

  logic is_head, is_tail, is_trig_hdr;
  logic absorb, trig_start, trig_end;

  logic          bypass_q, bypass_d;
  logic          start_q, start_d;
  logic          finish_q, finish_d;

  logic [133:0]  data_q;
  logic          data_wr_q;
  logic          valid_q, valid_wr_q;
  logic [1023:0] phv_q;
  logic          phv_wr_q;

  logic [133:0]  cout_data_q;
  logic          cout_wr_q;

  logic              cfg_hit;
  logic              ram_wr_en_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [143:0]      ram_wdata_q;

  assign is_head     = in_wr_data_wr && (in_wr_data[133:132] == 2'b01);
  assign is_tail     = in_wr_data_wr && (in_wr_data[133:132] == 2'b10);
  assign is_trig_hdr = (in_wr_data[111:109] == 3'b111);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (is_head) begin
          state_d = is_trig_hdr ? StTrig : StFwd;
        end
      end
      StFwd: begin
        if (is_tail) state_d = StIdle;
      end
      StTrig: begin
        if (is_tail) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode: everything belonging to a trigger packet is swallowed here
  always_comb begin
    absorb     = 1'b0;
    trig_start = 1'b0;
    trig_end   = 1'b0;
    case (state_q)
      StIdle: begin
        if (is_head && is_trig_hdr) begin
          absorb     = 1'b1;
          trig_start = 1'b1;
        end
      end
      StTrig: begin
        absorb   = 1'b1;
        trig_end = is_tail;
      end
      default: ;
    endcase
  end

  always_comb begin
    bypass_d = bypass_q;
    if (trig_start) bypass_d = 1'b0;
    if (trig_end)   bypass_d = 1'b1;
    start_d  = trig_start;
    finish_d = trig_end;
  end

  assign cfg_hit = cin_wr_data_wr
                && (cin_wr_data[133:132] == 2'b01)
                && cin_wr_data[127]
                && (cin_wr_data[126:124] == 3'b001)
                && (cin_wr_data[111:104] == MODULE_ID)
                && (cin_wr_data[95:80] == 16'h0001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_q    <= 1'b1;
      start_q     <= 1'b0;
      finish_q    <= 1'b0;
      data_q      <= '0;
      data_wr_q   <= 1'b0;
      valid_q     <= 1'b0;
      valid_wr_q  <= 1'b0;
      phv_q       <= '0;
      phv_wr_q    <= 1'b0;
      cout_data_q <= '0;
      cout_wr_q   <= 1'b0;
      ram_wr_en_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      bypass_q    <= bypass_d;
      start_q     <= start_d;
      finish_q    <= finish_d;
      data_q      <= in_wr_data;
      data_wr_q   <= in_wr_data_wr & ~absorb;
      valid_q     <= in_wr_valid;
      valid_wr_q  <= in_wr_valid_wr & ~absorb;
      phv_q       <= in_wr_phv;
      phv_wr_q    <= in_wr_phv_wr & ~absorb;
      cout_data_q <= cin_wr_data;
      cout_wr_q   <= cin_wr_data_wr;
      ram_wr_en_q <= cfg_hit;
      if (cfg_hit) begin
        ram_addr_q  <= cin_wr_data[64 +: RAM_AW];
        ram_wdata_q <= {80'b0, cin_wr_data[63:0]};
      end
    end
  end

  assign out_wr_alf           = in_wr_alf;
  assign out_wr_phv_alf       = in_wr_phv_alf;
  assign cout_wr_ready        = cin_wr_ready;

  assign out_wr_data          = data_q;
  assign out_wr_data_wr       = data_wr_q;
  assign out_wr_valid         = valid_q;
  assign out_wr_valid_wr      = valid_wr_q;
  assign out_wr_phv           = phv_q;
  assign out_wr_phv_wr        = phv_wr_q;

  assign pgm_bypass_flag      = bypass_q;
  assign pgm_sent_start_flag  = start_q;
  assign pgm_sent_finish_flag = finish_q;

  assign cout_wr_data         = cout_data_q;
  assign cout_wr_data_wr      = cout_wr_q;

  assign wr2ram_wr_en         = ram_wr_en_q;
  assign wr2ram_addr          = ram_addr_q;
  assign wr2ram_wdata         = ram_wdata_q;

endmodule

// File: tb/tb_pgm_wr.sv
// Directed bench for pgm_wr: expected beats/PHVs/RAM writes are queued at drive time
// and popped by negedge monitors when the DUT strobes its outputs.
module tb_pgm_wr;

  localparam int unsigned RamAw = 7;

  typedef struct packed {
    logic [RamAw-1:0] addr;
    logic [143:0]     wdata;
  } ram_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1023:0]     in_wr_phv;
  logic              in_wr_phv_wr;
  logic              out_wr_phv_alf;
  logic [133:0]      in_wr_data;
  logic              in_wr_data_wr;
  logic              in_wr_valid_wr;
  logic              in_wr_valid;
  logic              out_wr_alf;
  logic [1023:0]     out_wr_phv;
  logic              out_wr_phv_wr;
  logic              in_wr_phv_alf;
  logic [133:0]      out_wr_data;
  logic              out_wr_data_wr;
  logic              out_wr_valid;
  logic              out_wr_valid_wr;
  logic              in_wr_alf;
  logic              wr2ram_wr_en;
  logic [143:0]      wr2ram_wdata;
  logic [RamAw-1:0]  wr2ram_addr;
  logic              pgm_bypass_flag;
  logic              pgm_sent_start_flag;
  logic              pgm_sent_finish_flag;
  logic [133:0]      cin_wr_data;
  logic              cin_wr_data_wr;
  logic              cout_wr_ready;
  logic [133:0]      cout_wr_data;
  logic              cout_wr_data_wr;
  logic              cin_wr_ready;

  always #5 clk = ~clk;

  pgm_wr #(
    .MODULE_ID (8'd70),
    .RAM_AW    (RamAw)
  ) u_dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_wr_phv            (in_wr_phv),
    .in_wr_phv_wr         (in_wr_phv_wr),
    .out_wr_phv_alf       (out_wr_phv_alf),
    .in_wr_data           (in_wr_data),
    .in_wr_data_wr        (in_wr_data_wr),
    .in_wr_valid_wr       (in_wr_valid_wr),
    .in_wr_valid          (in_wr_valid),
    .out_wr_alf           (out_wr_alf),
    .out_wr_phv           (out_wr_phv),
    .out_wr_phv_wr        (out_wr_phv_wr),
    .in_wr_phv_alf        (in_wr_phv_alf),
    .out_wr_data          (out_wr_data),
    .out_wr_data_wr       (out_wr_data_wr),
    .out_wr_valid         (out_wr_valid),
    .out_wr_valid_wr      (out_wr_valid_wr),
    .in_wr_alf            (in_wr_alf),
    .wr2ram_wr_en         (wr2ram_wr_en),
    .wr2ram_wdata         (wr2ram_wdata),
    .wr2ram_addr          (wr2ram_addr),
    .pgm_bypass_flag      (pgm_bypass_flag),
    .pgm_sent_start_flag  (pgm_sent_start_flag),
    .pgm_sent_finish_flag (pgm_sent_finish_flag),
    .cin_wr_data          (cin_wr_data),
    .cin_wr_data_wr       (cin_wr_data_wr),
    .cout_wr_ready        (cout_wr_ready),
    .cout_wr_data         (cout_wr_data),
    .cout_wr_data_wr      (cout_wr_data_wr),
    .cin_wr_ready         (cin_wr_ready)
  );

  logic [133:0]  exp_data_q[$];
  logic          exp_valid_q[$];
  logic [1023:0] exp_phv_q[$];
  logic [133:0]  exp_cout_q[$];
  ram_t          exp_ram_q[$];

  int total = 0;
  int bad   = 0;

  // Only the low 160 bits are printed to keep lines short.
  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[159:0], exp[159:0]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_wr_data_wr) begin
        if (exp_data_q.size() == 0) chk("data_unexpected", 1024'(out_wr_data_wr), 1024'(1'b0));
        else chk("out_data", 1024'(out_wr_data), 1024'(exp_data_q.pop_front()));
      end
      if (out_wr_valid_wr) begin
        if (exp_valid_q.size() == 0) chk("valid_unexpected", 1024'(out_wr_valid_wr), 1024'(1'b0));
        else chk("out_valid", 1024'(out_wr_valid), 1024'(exp_valid_q.pop_front()));
      end
      if (out_wr_phv_wr) begin
        if (exp_phv_q.size() == 0) chk("phv_unexpected", 1024'(out_wr_phv_wr), 1024'(1'b0));
        else chk("out_phv", out_wr_phv, exp_phv_q.pop_front());
      end
      if (cout_wr_data_wr) begin
        if (exp_cout_q.size() == 0) chk("cout_unexpected", 1024'(cout_wr_data_wr), 1024'(1'b0));
        else chk("cout_data", 1024'(cout_wr_data), 1024'(exp_cout_q.pop_front()));
      end
      if (wr2ram_wr_en) begin
        if (exp_ram_q.size() == 0) chk("ram_unexpected", 1024'(wr2ram_wr_en), 1024'(1'b0));
        else chk("ram_write", 1024'({wr2ram_addr, wr2ram_wdata}), 1024'(exp_ram_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] rphv();
    logic [1023:0] p;
    for (int i = 0; i < 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic logic [133:0] dbeat(input logic [1:0] hdr, input logic [2:0] kind);
    logic [133:0] b;
    b = {6'($urandom), $urandom, $urandom, $urandom, $urandom};
    b[133:132] = hdr;
    b[111:109] = kind;
    return b;
  endfunction

  function automatic logic [133:0] cbeat(input logic [1:0] hdr, input logic rw,
                                         input logic [2:0] op, input logic [7:0] id,
                                         input logic [15:0] hi, input logic [15:0] lo,
                                         input logic [63:0] d);
    logic [133:0] b;
    b = {6'($urandom), $urandom, $urandom, $urandom, $urandom};
    b[133:132] = hdr;
    b[127]     = rw;
    b[126:124] = op;
    b[111:104] = id;
    b[95:80]   = hi;
    b[79:64]   = lo;
    b[63:0]    = d;
    return b;
  endfunction

  task automatic drive_d(input logic [133:0] b, input logic vwr, input logic v, input logic pwr,
                         input logic [1023:0] p, input logic fwd);
    in_wr_data     = b;
    in_wr_data_wr  = 1'b1;
    in_wr_valid_wr = vwr;
    in_wr_valid    = v;
    in_wr_phv_wr   = pwr;
    in_wr_phv      = p;
    if (fwd) begin
      exp_data_q.push_back(b);
      if (vwr) exp_valid_q.push_back(v);
      if (pwr) exp_phv_q.push_back(p);
    end
  endtask

  task automatic clr_d();
    in_wr_data_wr  = 1'b0;
    in_wr_valid_wr = 1'b0;
    in_wr_phv_wr   = 1'b0;
  endtask

  task automatic drive_c(input logic [133:0] b, input logic wr_exp, input logic [RamAw-1:0] a,
                         input logic [63:0] d);
    ram_t r;
    cin_wr_data    = b;
    cin_wr_data_wr = 1'b1;
    exp_cout_q.push_back(b);
    if (wr_exp) begin
      r.addr  = a;
      r.wdata = {80'b0, d};
      exp_ram_q.push_back(r);
    end
  endtask

  initial begin
    logic [63:0] d;
    rst_n          = 1'b0;
    in_wr_phv      = '0;
    in_wr_phv_wr   = 1'b0;
    in_wr_data     = '0;
    in_wr_data_wr  = 1'b0;
    in_wr_valid_wr = 1'b0;
    in_wr_valid    = 1'b0;
    in_wr_phv_alf  = 1'b0;
    in_wr_alf      = 1'b0;
    cin_wr_data    = '0;
    cin_wr_data_wr = 1'b0;
    cin_wr_ready   = 1'b0;
    repeat (3) cyc();

    chk("rst_bypass", 1024'(pgm_bypass_flag), 1024'(1'b1));
    chk("rst_start", 1024'(pgm_sent_start_flag), 1024'(1'b0));
    chk("rst_finish", 1024'(pgm_sent_finish_flag), 1024'(1'b0));
    chk("rst_data_wr", 1024'(out_wr_data_wr), 1024'(1'b0));
    chk("rst_data", 1024'(out_wr_data), 1024'(134'b0));
    chk("rst_ram_en", 1024'(wr2ram_wr_en), 1024'(1'b0));
    chk("rst_cout_wr", 1024'(cout_wr_data_wr), 1024'(1'b0));
    rst_n = 1'b1;
    cyc();

    // Plain 4-beat packet: forwarded, control flags untouched
    for (int i = 0; i < 4; i++) begin
      drive_d(dbeat((i == 0) ? 2'b01 : ((i == 3) ? 2'b10 : 2'b11), 3'b000),
              (i == 3), 1'b1, (i == 0), rphv(), 1'b1);
      cyc();
      chk("pkt_bypass", 1024'(pgm_bypass_flag), 1024'(1'b1));
      chk("pkt_start", 1024'(pgm_sent_start_flag), 1024'(1'b0));
    end
    clr_d();
    cyc();

    // Trigger packet: absorbed, start pulse, then finish pulse on tail
    drive_d(dbeat(2'b01, 3'b111), 1'b0, 1'b0, 1'b1, rphv(), 1'b0);
    cyc();
    chk("trig_start", 1024'(pgm_sent_start_flag), 1024'(1'b1));
    chk("trig_bypass0", 1024'(pgm_bypass_flag), 1024'(1'b0));
    chk("trig_no_fwd", 1024'(out_wr_data_wr), 1024'(1'b0));
    drive_d(dbeat(2'b11, 3'b000), 1'b0, 1'b0, 1'b1, rphv(), 1'b0);
    cyc();
    chk("trig_start_pulse", 1024'(pgm_sent_start_flag), 1024'(1'b0));
    chk("trig_bypass_hold", 1024'(pgm_bypass_flag), 1024'(1'b0));
    chk("trig_finish_early", 1024'(pgm_sent_finish_flag), 1024'(1'b0));
    drive_d(dbeat(2'b10, 3'b000), 1'b1, 1'b1, 1'b0, rphv(), 1'b0);
    cyc();
    chk("trig_finish", 1024'(pgm_sent_finish_flag), 1024'(1'b1));
    chk("trig_bypass1", 1024'(pgm_bypass_flag), 1024'(1'b1));
    clr_d();
    cyc();
    chk("trig_finish_pulse", 1024'(pgm_sent_finish_flag), 1024'(1'b0));

    // Config writes, with a data packet running concurrently
    d = 64'hffffffff_00000000;
    drive_c(cbeat(2'b01, 1'b1, 3'b001, 8'd70, 16'h0001, 16'h0001, d), 1'b1, 7'd1, d);
    drive_d(dbeat(2'b01, 3'b010), 1'b0, 1'b0, 1'b1, rphv(), 1'b1);
    cyc();
    chk("cfg_wr_en", 1024'(wr2ram_wr_en), 1024'(1'b1));
    chk("cfg_addr", 1024'(wr2ram_addr), 1024'(7'd1));
    chk("cfg_wdata", 1024'(wr2ram_wdata), 1024'({80'b0, 64'hffffffff_00000000}));
    drive_c(cbeat(2'b10, 1'b1, 3'b001, 8'd70, 16'h0001, 16'h0001, d), 1'b0, '0, '0);
    drive_d(dbeat(2'b10, 3'b000), 1'b1, 1'b0, 1'b0, rphv(), 1'b1);
    cyc();
    chk("cfg_tail_no_wr", 1024'(wr2ram_wr_en), 1024'(1'b0));
    clr_d();
    drive_c(cbeat(2'b01, 1'b1, 3'b001, 8'd71, 16'h0001, 16'h0002, $urandom), 1'b0, '0, '0);
    cyc();
    chk("cfg_id71_no_wr", 1024'(wr2ram_wr_en), 1024'(1'b0));
    drive_c(cbeat(2'b01, 1'b0, 3'b001, 8'd70, 16'h0001, 16'h0003, $urandom), 1'b0, '0, '0);
    cyc();
    chk("cfg_read_no_wr", 1024'(wr2ram_wr_en), 1024'(1'b0));
    d = {$urandom, $urandom};
    drive_c(cbeat(2'b01, 1'b1, 3'b001, 8'd70, 16'h0001, 16'h0055, d), 1'b1, 7'h55, d);
    cyc();
    chk("cfg_addr55", 1024'(wr2ram_addr), 1024'(7'h55));
    cin_wr_data_wr = 1'b0;
    cyc();
    chk("cfg_idle", 1024'(wr2ram_wr_en), 1024'(1'b0));

    // Combinational backpressure
    in_wr_alf = 1'b1;
    #1;
    chk("alf_hi", 1024'(out_wr_alf), 1024'(1'b1));
    in_wr_alf     = 1'b0;
    in_wr_phv_alf = 1'b1;
    cin_wr_ready  = 1'b1;
    #1;
    chk("alf_lo", 1024'(out_wr_alf), 1024'(1'b0));
    chk("phv_alf_hi", 1024'(out_wr_phv_alf), 1024'(1'b1));
    chk("ready_hi", 1024'(cout_wr_ready), 1024'(1'b1));
    in_wr_phv_alf = 1'b0;
    cin_wr_ready  = 1'b0;
    cyc();

    // Reset in the middle of a trigger packet
    drive_d(dbeat(2'b01, 3'b111), 1'b0, 1'b0, 1'b1, rphv(), 1'b0);
    cyc();
    chk("mid_bypass0", 1024'(pgm_bypass_flag), 1024'(1'b0));
    drive_d(dbeat(2'b11, 3'b000), 1'b0, 1'b0, 1'b0, rphv(), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bypass", 1024'(pgm_bypass_flag), 1024'(1'b1));
    chk("mid_rst_start", 1024'(pgm_sent_start_flag), 1024'(1'b0));
    chk("mid_rst_phv_wr", 1024'(out_wr_phv_wr), 1024'(1'b0));
    chk("mid_rst_data", 1024'(out_wr_data), 1024'(134'b0));
    clr_d();
    cyc();
    rst_n = 1'b1;
    cyc();
    // FSM must be back in idle: this packet is forwarded, not absorbed
    drive_d(dbeat(2'b01, 3'b000), 1'b0, 1'b0, 1'b1, rphv(), 1'b1);
    cyc();
    drive_d(dbeat(2'b10, 3'b000), 1'b1, 1'b1, 1'b0, rphv(), 1'b1);
    cyc();
    clr_d();
    repeat (3) cyc();

    chk("left_data", 1024'(exp_data_q.size()), 1024'(0));
    chk("left_valid", 1024'(exp_valid_q.size()), 1024'(0));
    chk("left_phv", 1024'(exp_phv_q.size()), 1024'(0));
    chk("left_cout", 1024'(exp_cout_q.size()), 1024'(0));
    chk("left_ram", 1024'(exp_ram_q.size()), 1024'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
